// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM duty meter.
// Duty is reported on the same /1024 scale as the motor PWM generators.
package pwm_pkg;

  localparam int DUTY_W    = 10;
  localparam int DUTY_FULL = 1024;
  localparam int DUTY_MAX  = 1023;
  localparam int QUO_W     = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STUCK = 2'd2
  } state_e;

  // Quotient 1024 only occurs when high_time equals period.
  function automatic logic [DUTY_W-1:0] duty_clamp(
    input logic [QUO_W-1:0] q
  );
    return q[QUO_W-1] ? DUTY_W'(DUTY_MAX) : q[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/pwm_duty_meter_if.sv
// Measurement result bundle of the PWM duty meter.
// master drives the results, slave consumes them.
interface pwm_duty_meter_if #(
  parameter int CNT_W = 32
);
  import pwm_pkg::*;

  logic [CNT_W-1:0]  period;
  logic [CNT_W-1:0]  high_time;
  logic [DUTY_W-1:0] duty;
  logic              valid;
  logic              stuck_high;
  logic              stuck_low;
  logic              overrun;

  modport master (
    output period, high_time, duty,
    output valid, stuck_high, stuck_low,
    output overrun
  );

  modport slave (
    input period, high_time, duty,
    input valid, stuck_high, stuck_low,
    input overrun
  );

endinterface

// File: rtl/pwm_duty_div.sv
// Restoring divider: (hi<<10)/period, one quotient bit per cycle.
// done pulses together with the final quotient on quo.
module pwm_duty_div
  import pwm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W+9:0] num,
  input  logic [CNT_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [QUO_W-1:0] quo
);

  logic             busy_q, busy_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] den_q, den_d;
  logic [QUO_W-1:0] sh_q, sh_d;

  logic [CNT_W:0]   shifted;
  logic [CNT_W-1:0] trial;
  logic [CNT_W-1:0] rem_n;
  logic [QUO_W-1:0] sh_n;
  logic             ge;

  // Upper numerator bits start in rem; hi<=period keeps them below den.
  always_comb begin
    shifted = {rem_q, sh_q[QUO_W-1]};
    ge      = shifted >= {1'b0, den_q};
    trial   = shifted[CNT_W-1:0] - den_q;
    rem_n   = ge ? trial : shifted[CNT_W-1:0];
    sh_n    = {sh_q[QUO_W-2:0], ge};
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    den_d  = den_q;
    sh_d   = sh_q;
    done   = 1'b0;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = 4'd11;
      rem_d  = {1'b0, num[CNT_W+9:11]};
      den_d  = den;
      sh_d   = num[10:0];
    end else if (busy_q) begin
      rem_d = rem_n;
      sh_d  = sh_n;
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        busy_d = 1'b0;
        done   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      sh_q   <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      den_q  <= den_d;
      sh_q   <= sh_d;
    end
  end

  assign busy = busy_q;
  assign quo  = sh_n;

endmodule

// File: rtl/pwm_duty_meter.sv
// PWM input meter: period, high time and /1024 duty per rising edge,
// with stuck-high/stuck-low detection when edges stop arriving.
module pwm_duty_meter
  import pwm_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT     = 100000,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pwm_in,
  pwm_duty_meter_if.master res
);

  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t TMO  = cnt_t'(TIMEOUT);
  localparam cnt_t CMAX = '1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic s, s_dly_q, s_dly_d, rise;

  state_e state_q, state_d;
  cnt_t per_q, per_d, hi_q, hi_d;
  cnt_t idle_q, idle_d;
  cnt_t hper_q, hper_d, hhi_q, hhi_d;
  cnt_t period_q, period_d, high_q, high_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic valid_q, valid_d, ovr_q, ovr_d;
  logic sth_q, sth_d, stl_q, stl_d;

  cnt_t per_inc, hi_inc;
  logic go_stuck;
  logic div_start, div_busy, div_done;
  logic [QUO_W-1:0] div_quo;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_dly_q;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], pwm_in};
    s_dly_d = s;
    per_inc = (per_q == CMAX) ? per_q : per_q + 1'b1;
    hi_inc  = (s && hi_q != CMAX) ? hi_q + 1'b1 : hi_q;
  end

  always_comb begin
    state_d   = state_q;
    per_d     = per_q;
    hi_d      = hi_q;
    idle_d    = '0;
    hper_d    = hper_q;
    hhi_d     = hhi_q;
    period_d  = period_q;
    high_d    = high_q;
    duty_d    = duty_q;
    sth_d     = sth_q;
    stl_d     = stl_q;
    valid_d   = 1'b0;
    ovr_d     = 1'b0;
    div_start = 1'b0;
    go_stuck  = 1'b0;

    if (div_done) begin
      period_d = hper_q;
      high_d   = hhi_q;
      duty_d   = duty_clamp(div_quo);
      valid_d  = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        per_d = '0;
        hi_d  = '0;
        if (rise) begin
          state_d = RUN;
        end else if (idle_q == TMO) begin
          go_stuck = 1'b1;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      RUN: begin
        if (rise) begin
          per_d = '0;
          hi_d  = '0;
          if (div_busy) begin
            ovr_d = 1'b1;
          end else begin
            div_start = 1'b1;
            hper_d    = per_inc;
            hhi_d     = hi_inc;
          end
        end else if (per_q == TMO) begin
          go_stuck = 1'b1;
        end else begin
          per_d = per_inc;
          hi_d  = hi_inc;
        end
      end
      STUCK: begin
        per_d = '0;
        hi_d  = '0;
        if (rise) begin
          state_d = RUN;
          sth_d   = 1'b0;
          stl_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Stuck report replaces any result for this cycle.
    if (go_stuck) begin
      state_d  = STUCK;
      per_d    = '0;
      hi_d     = '0;
      sth_d    = s;
      stl_d    = ~s;
      period_d = '0;
      high_d   = '0;
      duty_d   = s ? DUTY_W'(DUTY_MAX) : '0;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      s_dly_q  <= 1'b0;
      state_q  <= IDLE;
      per_q    <= '0;
      hi_q     <= '0;
      idle_q   <= '0;
      hper_q   <= '0;
      hhi_q    <= '0;
      period_q <= '0;
      high_q   <= '0;
      duty_q   <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
      sth_q    <= 1'b0;
      stl_q    <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      s_dly_q  <= s_dly_d;
      state_q  <= state_d;
      per_q    <= per_d;
      hi_q     <= hi_d;
      idle_q   <= idle_d;
      hper_q   <= hper_d;
      hhi_q    <= hhi_d;
      period_q <= period_d;
      high_q   <= high_d;
      duty_q   <= duty_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
      sth_q    <= sth_d;
      stl_q    <= stl_d;
    end
  end

  pwm_duty_div #(
    .CNT_W(CNT_W)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .start (div_start),
    .num   ({hi_inc, 10'b0}),
    .den   (per_inc),
    .busy  (div_busy),
    .done  (div_done),
    .quo   (div_quo)
  );

  assign res.period     = period_q;
  assign res.high_time  = high_q;
  assign res.duty       = duty_q;
  assign res.valid      = valid_q;
  assign res.stuck_high = sth_q;
  assign res.stuck_low  = stl_q;
  assign res.overrun    = ovr_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Bench for pwm_duty_meter: table-driven PWM periods plus
// stuck, overrun and reset-abort sequences, scoreboard-checked.
module tb_pwm_duty_meter;

  localparam int TMO = 4500;
  localparam int IDLE = 0, RUN = 1, STUCK = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pwm_in = 1'b0;
  longint cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pwm_duty_meter_if #(.CNT_W(32)) bus ();

  pwm_duty_meter #(
    .CNT_W(32), .TIMEOUT(TMO), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset),
    .pwm_in(pwm_in), .res(bus.master)
  );

  typedef struct {
    longint      due;
    logic [31:0] per;
    logic [31:0] hi;
    logic [9:0]  duty;
    logic        sh;
    logic        sl;
  } exp_t;

  typedef struct {
    int         hi;
    int         per;
    logic [9:0] duty;
  } vec_t;

  exp_t   exp_q[$];
  longint ovr_q[$];
  int n_cmp = 0;
  int n_err = 0;

  int     st = IDLE;
  int     per_acc = 0, hi_acc = 0;
  logic   last_v = 1'b0;
  longint last_start = -1000;
  logic [9:0] run_duty = '0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d required=%0d",
               nm, cyc, act, req);
    end
  endtask

  task automatic flag_fail(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s cyc=%0d got=event required=none",
             nm, cyc);
  endtask

  // Rise at drive cycle N is detected at N+2: valid at N+14,
  // overrun at N+3; a busy divider spans 12 cycles.
  task automatic drive_bit(input logic v);
    exp_t e;
    @(negedge clk);
    pwm_in = v;
    if (v && !last_v) begin
      if (st == RUN) begin
        if (cyc - last_start < 12) begin
          ovr_q.push_back(cyc + 3);
        end else begin
          e.due = cyc + 14; e.per = per_acc; e.hi = hi_acc;
          e.duty = run_duty; e.sh = 1'b0; e.sl = 1'b0;
          exp_q.push_back(e);
          last_start = cyc;
        end
      end
      st = RUN;
      per_acc = 1;
      hi_acc = 1;
    end else begin
      per_acc++;
      hi_acc += int'(v);
    end
    last_v = v;
  endtask

  task automatic gen_period(input int hi, input int per,
                            input logic [9:0] duty);
    for (int i = 0; i < per; i++) begin
      drive_bit(i < hi);
      if (i == 0) run_duty = duty;
    end
  endtask

  task automatic push_stuck(input logic sh);
    exp_t e;
    e.due = -1; e.per = 0; e.hi = 0;
    e.duty = sh ? 10'd1023 : 10'd0;
    e.sh = sh; e.sl = ~sh;
    exp_q.push_back(e);
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1;
    reset = 1'b1;
    pwm_in = 1'b0;
    exp_q.delete();
    ovr_q.delete();
    st = IDLE; last_v = 1'b0; last_start = -1000;
    per_acc = 0; hi_acc = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (exp_q.size() > 0 && exp_q[0].due >= 0 &&
          exp_q[0].due < cyc) begin
        chk("valid_missing", 0, 1);
        void'(exp_q.pop_front());
      end
      if (bus.valid) begin
        if (exp_q.size() == 0) begin
          flag_fail("unexpected_valid");
        end else begin
          e = exp_q.pop_front();
          if (e.due >= 0) chk("valid_cycle", cyc, e.due);
          chk("period", bus.period, e.per);
          chk("high_time", bus.high_time, e.hi);
          chk("duty", bus.duty, e.duty);
          chk("stuck_high", bus.stuck_high, e.sh);
          chk("stuck_low", bus.stuck_low, e.sl);
        end
      end
      if (ovr_q.size() > 0 && ovr_q[0] < cyc) begin
        chk("overrun_missing", 0, 1);
        void'(ovr_q.pop_front());
      end
      if (bus.overrun) begin
        if (ovr_q.size() == 0) flag_fail("unexpected_overrun");
        else chk("overrun_cycle", cyc, ovr_q.pop_front());
      end
    end
  end

  vec_t tbl[9];

  initial begin
    tbl[0] = '{2968, 4001, 10'd759};
    tbl[1] = '{4000, 4001, 10'd1023};
    tbl[2] = '{1,    4001, 10'd0};
    tbl[3] = '{2000, 4000, 10'd512};
    tbl[4] = '{100,  200,  10'd512};
    tbl[5] = '{13,   100,  10'd133};
    tbl[6] = '{99,   100,  10'd1013};
    tbl[7] = '{7,    13,   10'd551};
    tbl[8] = '{1,    12,   10'd85};

    reset_dut();
    @(negedge clk);
    chk("rst_period", bus.period, 0);
    chk("rst_high", bus.high_time, 0);
    chk("rst_duty", bus.duty, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_sth", bus.stuck_high, 0);
    chk("rst_stl", bus.stuck_low, 0);
    chk("rst_ovr", bus.overrun, 0);

    foreach (tbl[i]) gen_period(tbl[i].hi, tbl[i].per, tbl[i].duty);

    // 8-cycle square wave: every other rise overruns.
    repeat (6) gen_period(4, 8, 10'd512);
    gen_period(2968, 4001, 10'd759);

    // Held high until timeout, then released.
    drive_bit(1'b1);
    push_stuck(1'b1);
    repeat (TMO + 60) drive_bit(1'b1);
    chk("sh_flag", bus.stuck_high, 1);
    chk("sh_low_flag", bus.stuck_low, 0);
    chk("sh_duty", bus.duty, 1023);
    chk("sh_drained", exp_q.size(), 0);
    st = STUCK;
    repeat (5) drive_bit(1'b0);
    gen_period(2968, 4001, 10'd759);
    chk("sh_cleared", bus.stuck_high, 0);
    gen_period(1, 4001, 10'd0);

    // Held low until timeout from RUN.
    drive_bit(1'b1);
    push_stuck(1'b0);
    repeat (TMO + 60) drive_bit(1'b0);
    chk("sl_flag", bus.stuck_low, 1);
    chk("sl_period", bus.period, 0);
    chk("sl_drained", exp_q.size(), 0);
    st = STUCK;

    // Reset during a division: nothing must be reported.
    reset_dut();
    gen_period(10, 20, 10'd512);
    drive_bit(1'b1);
    repeat (6) drive_bit(1'b1);
    reset_dut();
    @(negedge clk);
    chk("abort_period", bus.period, 0);
    chk("abort_duty", bus.duty, 0);
    chk("abort_valid", bus.valid, 0);
    repeat (20) drive_bit(1'b0);
    gen_period(10, 20, 10'd512);
    gen_period(12, 24, 10'd512);
    drive_bit(1'b1);
    repeat (20) drive_bit(1'b0);

    // Held low from reset.
    reset_dut();
    push_stuck(1'b0);
    repeat (TMO + 60) drive_bit(1'b0);
    chk("idle_sl_flag", bus.stuck_low, 1);
    chk("idle_sl_duty", bus.duty, 0);

    repeat (30) drive_bit(1'b0);
    chk("exp_queue_empty", exp_q.size(), 0);
    chk("ovr_queue_empty", ovr_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
